// File: rtl/multicycle_core_if.sv
// Instruction- and data-memory handshake bundle for multicycle_core.
// The core is the master; memories (or the bench) sit on the slave side.
interface multicycle_core_if #(
    parameter int DATA_W  = 32,
    parameter int PC_W    = 8,
    parameter int DMEM_AW = 4
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic [31:0]        imem_rdata;
    logic               imem_ack;

    logic               dmem_req;
    logic               dmem_we;
    logic [DMEM_AW-1:0] dmem_addr;
    logic [DATA_W-1:0]  dmem_wdata;
    logic [DATA_W-1:0]  dmem_rdata;
    logic               dmem_ack;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata, imem_ack,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata, imem_ack,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/multicycle_core.sv
// Multi-cycle core: FETCH/DECODE/EXEC/MEM/WB/HALT sequencer with internal
// register file and ALU; instruction and data memories sit behind req/ack.
module multicycle_core #(
    parameter int DATA_W  = 32,
    parameter int PC_W    = 8,
    parameter int DMEM_AW = 4
) (
    input  logic              clk,
    input  logic              counterRst,
    input  logic              counterLd,
    multicycle_core_if.master bus,
    output logic              instr_done,
    output logic              halted
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    function automatic logic [DATA_W-1:0] sext_data(input logic [15:0] v);
        logic [DATA_W-1:0] r;
        r       = {DATA_W{v[15]}};
        r[15:0] = v;
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] zext_data(input logic [15:0] v);
        logic [DATA_W-1:0] r;
        r       = '0;
        r[15:0] = v;
        return r;
    endfunction

    // Branch offsets are sign-extended (or truncated) to the PC width.
    function automatic logic [PC_W-1:0] sext_pc(input logic [15:0] v);
        logic [PC_W-1:0] r;
        r = {PC_W{v[15]}};
        for (int i = 0; i < 16 && i < PC_W; i++) begin
            r[i] = v[i];
        end
        return r;
    endfunction

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] rf_q [32];

    logic [5:0]        op;
    logic [4:0]        rs, rt, rd;
    logic [2:0]        funct;
    logic [DATA_W-1:0] simm, zimm;
    logic [PC_W-1:0]   br_off;

    logic signed [DATA_W-1:0] a_s, b_s;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] slt_res;

    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    logic               imem_req_o;
    logic               dmem_req_o;
    logic               dmem_we_o;
    logic [DMEM_AW-1:0] dmem_addr_o;
    logic [DATA_W-1:0]  dmem_wdata_o;
    logic               halted_o;

    assign op     = ir_q[31:26];
    assign rs     = ir_q[25:21];
    assign rt     = ir_q[20:16];
    assign rd     = ir_q[15:11];
    assign funct  = ir_q[2:0];
    assign simm   = sext_data(ir_q[15:0]);
    assign zimm   = zext_data(ir_q[15:0]);
    assign br_off = sext_pc(ir_q[15:0]);
    assign a_s    = a_q;
    assign b_s    = b_q;

    always_comb begin
        alu_res     = a_q + b_q;
        slt_res     = '0;
        slt_res[0]  = (a_s < b_s);
        case (op)
            OP_RTYPE: begin
                case (funct)
                    3'd1:    alu_res = a_q - b_q;
                    3'd2:    alu_res = a_q & b_q;
                    3'd3:    alu_res = a_q | b_q;
                    3'd4:    alu_res = slt_res;
                    3'd5:    alu_res = a_q ^ b_q;
                    default: alu_res = a_q + b_q;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: alu_res = a_q + simm;
            OP_ORI:                alu_res = a_q | zimm;
            default:               alu_res = a_q + b_q;
        endcase
    end

    assign rf_waddr = (op == OP_RTYPE) ? rd : rt;
    assign rf_wdata = (op == OP_LW) ? mdr_q : alu_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        a_d          = a_q;
        b_d          = b_q;
        alu_d        = alu_q;
        mdr_d        = mdr_q;
        done_d       = 1'b0;
        rf_we        = 1'b0;
        imem_req_o   = 1'b0;
        dmem_req_o   = 1'b0;
        dmem_we_o    = 1'b0;
        dmem_addr_o  = '0;
        dmem_wdata_o = '0;
        halted_o     = 1'b0;

        case (state_q)
            S_FETCH: begin
                imem_req_o = counterLd;
                if (counterLd && bus.imem_ack) begin
                    ir_d    = bus.imem_rdata;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d = rf_q[rs];
                b_d = rf_q[rt];
                if (op == OP_J) begin
                    pc_d    = ir_q[PC_W-1:0];
                    done_d  = 1'b1;
                    state_d = S_FETCH;
                end else if (op == OP_HALT) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_d = alu_res;
                case (op)
                    OP_RTYPE, OP_ADDI, OP_ORI: state_d = S_WB;
                    OP_LW, OP_SW:              state_d = S_MEM;
                    OP_BEQ, OP_BNE: begin
                        // pc_q already points past the branch here.
                        if ((a_q == b_q) == (op == OP_BEQ)) begin
                            pc_d = pc_q + br_off;
                        end
                        done_d  = 1'b1;
                        state_d = S_FETCH;
                    end
                    default: begin
                        done_d  = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                dmem_req_o   = 1'b1;
                dmem_we_o    = (op == OP_SW);
                dmem_addr_o  = alu_q[DMEM_AW-1:0];
                dmem_wdata_o = b_q;
                if (bus.dmem_ack) begin
                    if (op == OP_SW) begin
                        done_d  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        mdr_d   = bus.dmem_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                done_d  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: begin
                halted_o = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge counterRst) begin
        if (counterRst) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
            done_q  <= done_d;
        end
    end

    // Register 0 is never written, so it always reads back as zero.
    always_ff @(posedge clk or posedge counterRst) begin
        if (counterRst) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else if (rf_we && (rf_waddr != 5'd0)) begin
            rf_q[rf_waddr] <= rf_wdata;
        end
    end

    assign bus.imem_req   = imem_req_o;
    assign bus.imem_addr  = pc_q;
    assign bus.dmem_req   = dmem_req_o;
    assign bus.dmem_we    = dmem_we_o;
    assign bus.dmem_addr  = dmem_addr_o;
    assign bus.dmem_wdata = dmem_wdata_o;
    assign instr_done     = done_q;
    assign halted         = halted_o;

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: zero-wait instruction memory and a
// data memory with programmable wait states.
module tb_multicycle_core;

    localparam int OP_J    = 8'h02;
    localparam int OP_BEQ  = 8'h04;
    localparam int OP_BNE  = 8'h05;
    localparam int OP_ADDI = 8'h08;
    localparam int OP_ORI  = 8'h0D;
    localparam int OP_LW   = 8'h23;
    localparam int OP_SW   = 8'h2B;

    logic clk;
    logic rst;
    logic counterLd;
    logic instr_done;
    logic halted;

    multicycle_core_if #(.DATA_W(32), .PC_W(8), .DMEM_AW(4)) bus ();

    multicycle_core #(.DATA_W(32), .PC_W(8), .DMEM_AW(4)) dut (
        .clk        (clk),
        .counterRst (rst),
        .counterLd  (counterLd),
        .bus        (bus),
        .instr_done (instr_done),
        .halted     (halted)
    );

    logic [31:0] imem  [256];
    logic [31:0] dmem  [16];
    logic [31:0] dinit [16];
    logic        load_req;
    int          dwait;
    logic [3:0]  dcnt;
    int          cyc;
    int          vectors;
    int          fails;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign bus.imem_rdata = imem[bus.imem_addr];
    assign bus.imem_ack   = bus.imem_req;
    assign bus.dmem_rdata = dmem[bus.dmem_addr];
    assign bus.dmem_ack   = bus.dmem_req && (int'(dcnt) == dwait);

    always @(posedge clk or posedge rst) begin
        if (rst) dcnt <= 4'd0;
        else if (bus.dmem_req) dcnt <= bus.dmem_ack ? 4'd0 : dcnt + 4'd1;
    end

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 16; i++) dmem[i] <= dinit[i];
        end else if (bus.dmem_req && bus.dmem_ack && bus.dmem_we) begin
            dmem[bus.dmem_addr] <= bus.dmem_wdata;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else cyc <= cyc + 1;
    end

    function automatic logic [31:0] rtype(int funct, int rd, int rs, int rt);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 8'h00, 3'(funct)};
    endfunction

    function automatic logic [31:0] itype(int op, int rt, int rs, int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] jtype(int tgt);
        return {6'h02, 26'(tgt)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag, input int exp_cyc);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (instr_done !== 1'b1 && n < 200);
        vectors++;
        assert (instr_done === 1'b1 && cyc == exp_cyc) else begin
            fails++;
            $error("FAIL %s: retire seen=%b at cycle %0d, expected retire at cycle %0d",
                   tag, instr_done, cyc, exp_cyc);
        end
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = {6'h01, 26'h0};
        for (int i = 0; i < 16; i++) dinit[i] = 32'h0;
    endtask

    task automatic reset_core(input logic ld, input int ws);
        @(negedge clk);
        rst       = 1'b1;
        counterLd = ld;
        dwait     = ws;
        load_req  = 1'b1;
        @(negedge clk);
        load_req  = 1'b0;
        @(negedge clk);
        rst       = 1'b0;
    endtask

    initial begin
        int n;
        vectors   = 0;
        fails     = 0;
        rst       = 1'b1;
        counterLd = 1'b0;
        load_req  = 1'b0;
        dwait     = 0;
        clear_imem();

        // Reset state and stall with counterLd low.
        repeat (2) @(negedge clk);
        chk("rst_imem_req", 64'(bus.imem_req), 64'd0);
        chk("rst_imem_addr", 64'(bus.imem_addr), 64'd0);
        chk("rst_dmem_req", 64'(bus.dmem_req), 64'd0);
        chk("rst_dmem_we", 64'(bus.dmem_we), 64'd0);
        chk("rst_dmem_addr", 64'(bus.dmem_addr), 64'd0);
        chk("rst_dmem_wdata", 64'(bus.dmem_wdata), 64'd0);
        chk("rst_instr_done", 64'(instr_done), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("stall_imem_req", 64'(bus.imem_req), 64'd0);
        chk("stall_pc", 64'(bus.imem_addr), 64'd0);
        chk("stall_done", 64'(instr_done), 64'd0);

        // Arithmetic, memory with 2 wait states, signed compare, r0, branches.
        imem[0]  = itype(OP_ADDI, 1, 0, 5);
        imem[1]  = itype(OP_ADDI, 2, 0, -3);
        imem[2]  = rtype(0, 3, 1, 2);
        imem[3]  = itype(OP_SW, 3, 0, 0);
        imem[4]  = itype(OP_LW, 4, 0, 0);
        imem[5]  = itype(OP_SW, 4, 1, -4);
        imem[6]  = itype(OP_ADDI, 6, 0, -1);
        imem[7]  = itype(OP_ADDI, 7, 0, 1);
        imem[8]  = rtype(4, 5, 6, 7);
        imem[9]  = rtype(4, 8, 7, 6);
        imem[10] = itype(OP_SW, 5, 0, 2);
        imem[11] = itype(OP_SW, 8, 0, 3);
        imem[12] = itype(OP_ADDI, 0, 0, 7);
        imem[13] = itype(OP_SW, 0, 0, 4);
        imem[14] = itype(OP_ORI, 9, 0, 16'h8001);
        imem[15] = rtype(5, 10, 9, 6);
        imem[16] = rtype(1, 11, 2, 1);
        imem[17] = rtype(2, 12, 10, 11);
        imem[18] = rtype(3, 13, 9, 11);
        imem[19] = itype(OP_BEQ, 0, 0, 1);
        imem[20] = itype(OP_ADDI, 9, 0, 16'h77);
        imem[21] = itype(OP_BNE, 0, 0, 1);
        imem[22] = itype(OP_SW, 9, 0, 5);
        imem[23] = itype(OP_SW, 10, 0, 6);
        imem[24] = itype(OP_SW, 11, 0, 7);
        imem[25] = itype(OP_SW, 12, 0, 8);
        imem[26] = itype(OP_SW, 13, 0, 9);
        imem[27] = rtype(6, 14, 1, 7);
        imem[28] = itype(OP_SW, 14, 0, 10);
        imem[29] = {6'h3F, 26'h0};
        dinit[3] = 32'hAAAA;
        dinit[4] = 32'hDEAD;
        reset_core(1'b1, 2);
        wait_done("a_addi1", 4);
        wait_done("a_addi2", 8);
        wait_done("a_add", 12);
        for (int k = 13; k <= 18; k++) begin
            @(negedge clk);
            chk("a_sw_req", 64'(bus.dmem_req), 64'(k >= 15 && k <= 17));
            chk("a_sw_done", 64'(instr_done), 64'(k == 18));
            if (k >= 15 && k <= 17) begin
                chk("a_sw_we", 64'(bus.dmem_we), 64'd1);
                chk("a_sw_addr", 64'(bus.dmem_addr), 64'd0);
                chk("a_sw_wdata", 64'(bus.dmem_wdata), 64'd2);
            end
        end
        wait_done("a_lw", 25);
        n = 0;
        while (halted !== 1'b1 && n < 800) begin
            @(negedge clk);
            n++;
        end
        chk("a_halted", 64'(halted), 64'd1);
        chk("a_halt_noreq", 64'(bus.imem_req), 64'd0);
        chk("a_r3_add", 64'(dmem[0]), 64'd2);
        chk("a_r4_lw", 64'(dmem[1]), 64'd2);
        chk("a_slt_neg", 64'(dmem[2]), 64'd1);
        chk("a_slt_pos", 64'(dmem[3]), 64'd0);
        chk("a_r0_zero", 64'(dmem[4]), 64'd0);
        chk("a_ori_zext", 64'(dmem[5]), 64'h0000_8001);
        chk("a_xor", 64'(dmem[6]), 64'hFFFF_7FFE);
        chk("a_sub", 64'(dmem[7]), 64'hFFFF_FFF8);
        chk("a_and", 64'(dmem[8]), 64'hFFFF_7FF8);
        chk("a_or", 64'(dmem[9]), 64'hFFFF_FFF9);
        chk("a_funct6_add", 64'(dmem[10]), 64'd6);

        // BNE back onto itself at PC 5; NOP latency.
        clear_imem();
        imem[0] = itype(OP_ADDI, 1, 0, 1);
        imem[5] = itype(OP_BNE, 0, 1, -1);
        imem[6] = {6'h3F, 26'h0};
        reset_core(1'b1, 0);
        wait_done("b_addi", 4);
        wait_done("b_nop1", 7);
        wait_done("b_nop2", 10);
        wait_done("b_nop3", 13);
        wait_done("b_nop4", 16);
        wait_done("b_bne1", 19);
        chk("b_bne_target", 64'(bus.imem_addr), 64'd5);
        chk("b_fetch_req", 64'(bus.imem_req), 64'd1);
        wait_done("b_bne2", 22);
        chk("b_bne_target2", 64'(bus.imem_addr), 64'd5);

        // Untaken BEQ at PC 255 wraps to 0.
        clear_imem();
        imem[0]   = itype(OP_ADDI, 1, 0, 1);
        imem[1]   = jtype(8'hFF);
        imem[255] = itype(OP_BEQ, 0, 1, 3);
        reset_core(1'b1, 0);
        wait_done("c_addi", 4);
        wait_done("c_j", 6);
        chk("c_j_target", 64'(bus.imem_addr), 64'hFF);
        wait_done("c_beq", 9);
        chk("c_pc_wrap", 64'(bus.imem_addr), 64'd0);

        // J then HALT; reset leaves HALT.
        clear_imem();
        imem[0]    = jtype(8'h10);
        imem[1]    = itype(OP_ADDI, 1, 0, 1);
        imem[8'h10] = {6'h3F, 26'h0};
        reset_core(1'b1, 0);
        wait_done("d_j", 2);
        chk("d_j_addr", 64'(bus.imem_addr), 64'h10);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("d_halted", 64'(halted), 64'd1);
            chk("d_halt_noreq", 64'(bus.imem_req), 64'd0);
            chk("d_halt_nodone", 64'(instr_done), 64'd0);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        chk("d_rst_halted", 64'(halted), 64'd0);
        chk("d_rst_pc", 64'(bus.imem_addr), 64'd0);

        // Reset in the middle of a store wait: no store, restart at PC 0.
        clear_imem();
        imem[0]  = itype(OP_ADDI, 1, 0, 9);
        imem[1]  = itype(OP_SW, 1, 0, 8);
        dinit[8] = 32'h55;
        reset_core(1'b1, 5);
        wait_done("e_addi", 4);
        repeat (5) @(negedge clk);
        chk("e_mem_req", 64'(bus.dmem_req), 64'd1);
        chk("e_mem_we", 64'(bus.dmem_we), 64'd1);
        rst = 1'b1;
        #1;
        chk("e_async_drop", 64'(bus.dmem_req), 64'd0);
        chk("e_async_we", 64'(bus.dmem_we), 64'd0);
        repeat (2) @(negedge clk);
        dwait = 0;
        rst   = 1'b0;
        chk("e_restart_pc", 64'(bus.imem_addr), 64'd0);
        chk("e_restart_req", 64'(bus.imem_req), 64'd1);
        chk("e_no_store", 64'(dmem[8]), 64'h55);
        wait_done("e_addi2", 4);
        wait_done("e_sw2", 8);
        @(negedge clk);
        chk("e_store_after", 64'(dmem[8]), 64'd9);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_core.md
# multicycle_core

Parametrised multi-cycle successor to the single-cycle datapath top. It executes the team's 32-bit instruction format in a shared FETCH/DECODE/EXEC/MEM/WB state machine. The register file and ALU are internal. Instruction and data memory sit outside the core, behind req/ack handshakes, so wait-state memories plug in directly. It adds signed branches, BNE, HALT, a hardwired-zero register and a retire strobe.

## Interface
- DATA_W, 32, datapath/register width (16..64)
- PC_W, 8, word-addressed PC width (1..26)
- DMEM_AW, 4, data memory word-address width (1..DATA_W)
- Reset is asynchronous and active-high on `counterRst`; one clock, `clk`.
- clk  in  1  rising-edge clock
- counterRst  in  1  async active-high reset
- counterLd  in  1  run enable, sampled only in FETCH
- imem_req  out  1  instruction fetch request
- imem_addr  out  PC_W  current PC
- imem_rdata  in  32  instruction, valid when imem_ack=1
- imem_ack  in  1  fetch complete
- dmem_req  out  1  data access request
- dmem_we  out  1  1=store, 0=load, valid with dmem_req
- dmem_addr  out  DMEM_AW  ALU result[DMEM_AW-1:0]
- dmem_wdata  out  DATA_W  rt value for stores
- dmem_rdata  in  DATA_W  load data, valid when dmem_ack=1
- dmem_ack  in  1  data access complete
- instr_done  out  1  one-cycle pulse when an instruction retires
- halted  out  1  core is in HALT

## Operation
- Instruction fields: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0], funct=[2:0].
- simm is imm sign-extended to DATA_W. zimm is imm zero-extended to DATA_W.
- R-type, op 0x00:
  - rd ← rs ∘ rt.
  - funct 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT (signed, result 1/0), 5 XOR; 6 and 7 execute as ADD.
- Immediate ops:
  - 0x08 ADDI: rt ← rs+simm.
  - 0x0D ORI: rt ← rs|zimm.
- Memory ops:
  - 0x23 LW: rt ← mem[rs+simm].
  - 0x2B SW: mem[rs+simm] ← rt.
- Branches:
  - 0x04 BEQ and 0x05 BNE: if taken, PC ← PC_next+simm[PC_W-1:0].
  - PC_next is the already-incremented PC.
- Jump and halt:
  - 0x02 J: PC ← inst[PC_W-1:0].
  - 0x3F HALT: enter HALT.
- Any other opcode is a NOP and retires without writes.
- All arithmetic is modulo 2^DATA_W. PC arithmetic wraps modulo 2^PC_W.
- Register 0 reads as 0; writes to it are discarded.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - imem_req=counterLd.
  - On imem_ack: IR ← imem_rdata, PC ← PC+1, go to DECODE.
- DECODE:
  - Latch A ← R[rs], B ← R[rt].
  - J updates PC, retires and returns to FETCH.
  - HALT goes to HALT.
  - All others go to EXEC.
- EXEC:
  - ALU result is latched.
  - Branches and NOPs retire here and go to FETCH.
  - LW and SW go to MEM; the rest go to WB.
- MEM:
  - dmem_req=1 with addr/we/wdata held until dmem_ack.
  - SW retires on ack and goes to FETCH.
  - LW latches dmem_rdata and goes to WB.
- WB: write the register file, retire, go to FETCH.
- HALT: all requests 0, halted=1. Only counterRst exits.
- instr_done is registered and asserted in the cycle after the retiring edge.

## Timing
- Reset values:
  - PC=0, state FETCH, all registers 0.
  - imem_req (while counterLd=0), dmem_req, dmem_we, dmem_addr, dmem_wdata, instr_done and halted are all 0.
- Reset clears all state and drops dmem_req immediately, mid-transaction included. imem_req then follows counterLd.
- Zero-wait memories (ack in the same cycle as req) give these latencies:
  - J: 2 cycles.
  - BEQ, BNE, NOP: 3 cycles.
  - R-type, ADDI, ORI, SW: 4 cycles.
  - LW: 5 cycles.
- Each ack cycle that is late adds exactly one cycle.
- Request outputs and address/data stay stable from req rise until the ack edge.
- Ack while req=0 is ignored.
- counterLd low in FETCH stalls with no request. An instruction already past FETCH completes regardless of counterLd.

## Test plan
- Reset, counterLd=1, zero-wait imem holding ADDI r1,r0,5 then ADDI r2,r0,-3 then ADD r3,r1,r2 -> r3=2, instr_done pulses at cycles 4, 8 and 12.
- SW r3,0(r0) then LW r4,0(r0) with 2-wait dmem -> dmem_we=1/addr=0/wdata=2 held 3 cycles; r4=2; LW takes 7 cycles.
- BNE r1,r0,-1 at PC=5 with r1≠0 -> next fetch at PC 5. BEQ at PC=255 with PC_W=8 not taken -> PC wraps to 0.
- SLT with r1=-1 and r2=1 -> 1. ADDI r0,r0,7 -> r0 still reads 0.
- J to 0x10 then HALT -> imem_addr=0x10, then halted=1 and no further imem_req. counterRst clears halted and PC.
- Assert counterRst during the MEM wait of an SW -> dmem_req drops asynchronously, no store is performed, and execution restarts at PC 0.
